// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one ALU_64_bit between two requesters,
// with a valid/ready request side and a registered, back-pressurable response.

module ALU_64_bit #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_aluOp,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    // Unlisted op codes produce zero; the arbiter masks them out anyway.
    always_comb begin
        o_result = '0;
        unique case (i_aluOp)
            4'b0000: o_result = i_a & i_b;
            4'b0001: o_result = i_a | i_b;
            4'b0010: o_result = i_a + i_b;
            4'b0110: o_result = i_a - i_b;
            4'b1100: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             r_state;
    logic               r_lastGrant;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic               r_id;

    logic               w_grant;
    logic               w_idle;
    logic               w_handshake;
    logic               w_opSupported;
    logic [WIDTH-1:0]   w_aluResult;
    logic               w_aluZero;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_lastGrant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Ready is gated by rst_n so nothing can be accepted while reset is held.
    assign w_idle      = rst_n && (r_state == IDLE);
    assign req0_ready  = w_idle && !w_grant && req0_valid;
    assign req1_ready  = w_idle &&  w_grant && req1_valid;
    assign w_handshake = req0_ready || req1_ready;
    assign busy        = (r_state != IDLE);

    always_comb begin
        unique case (r_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: w_opSupported = 1'b1;
            default:                                     w_opSupported = 1'b0;
        endcase
    end

    // The ALU only ever sees latched operands, so requesters may change inputs freely.
    ALU_64_bit #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_aluOp  (r_op),
        .o_result (w_aluResult),
        .o_zero   (w_aluZero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_a         <= w_grant ? req1_a  : req0_a;
                        r_b         <= w_grant ? req1_b  : req0_b;
                        r_op        <= w_grant ? req1_op : req0_op;
                        r_id        <= w_grant;
                        r_lastGrant <= w_grant;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    resp_valid  <= 1'b1;
                    resp_id     <= r_id;
                    resp_result <= w_opSupported ? w_aluResult : '0;
                    resp_zero   <= w_opSupported ? w_aluZero   : 1'b0;
                    resp_err    <= ~w_opSupported;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ops, round-robin, unsupported op,
// response backpressure and reset during an operation.

module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic [3:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [3:0]  req1_op;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [63:0] resp_result;
    logic        resp_zero;
    logic        resp_err;
    logic        busy;

    int checks;
    int failures;

    alu_arbiter #(
        .WIDTH(64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: valid=%b busy=%b id=%b want 0 0 0", resp_valid, busy, resp_id);
        end
        checks++;
        if (resp_result !== 64'h0 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_data: result=%h zero=%b err=%b want 0", resp_result, resp_zero, resp_err);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ops;
        logic [3:0]  ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};
        logic [63:0] exp [5] = '{64'h000000000000000F, 64'h0002300AB0000F0F,
                                 64'h0002300AB0000F1E, 64'hFFFDD00AAFFFF100,
                                 64'hFFFDCFF54FFFF0F0};
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_a     = 64'h0000000AB000000F;
            req0_b     = 64'h0002300000000F0F;
            req0_op    = ops[i];
            req0_valid = 1'b1;
            #1;
            checks++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL op%0d_ready: got %b%b want 10", i, req0_ready, req1_ready);
            end
            @(negedge clk);
            req0_valid = 1'b0;
            req0_a     = '1;
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL op%0d_exec: valid=%b busy=%b want 0 1", i, resp_valid, busy);
            end
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_result !== exp[i] || resp_zero !== 1'b0
                || resp_err !== 1'b0 || resp_id !== 1'b0) begin
                failures++;
                $display("[TB] FAIL op%0d_resp: valid=%b result=%h zero=%b err=%b id=%b want 1 %h 0 0 0",
                         i, resp_valid, resp_result, resp_zero, resp_err, resp_id, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        logic expId;
        rst_n      = 1'b0;
        req0_a = 64'd1; req0_b = 64'd2; req0_op = 4'b0010;
        req1_a = 64'd5; req1_b = 64'd5; req1_op = 4'b0110;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            expId = i[0];
            checks++;
            if (req0_ready !== ~expId || req1_ready !== expId) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d: got %b%b want %b%b", i, req0_ready, req1_ready, ~expId, expId);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== expId
                || resp_result !== (expId ? 64'd0 : 64'd3) || resp_zero !== expId) begin
                failures++;
                $display("[TB] FAIL rr_resp%0d: valid=%b id=%b result=%h zero=%b want 1 %b %h %b",
                         i, resp_valid, resp_id, resp_result, resp_zero, expId,
                         (expId ? 64'd0 : 64'd3), expId);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_error;
        resp_ready = 1'b1;
        req1_a     = 64'h5;
        req1_b     = 64'h7;
        req1_op    = 4'b0011;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_ready: got %b want 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_result !== 64'h0
            || resp_zero !== 1'b0 || resp_id !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_resp: valid=%b err=%b result=%h zero=%b id=%b want 1 1 0 0 1",
                     resp_valid, resp_err, resp_result, resp_zero, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        req0_a = 64'd10; req0_b = 64'd20; req0_op = 4'b0010;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_a = 64'd99;
        req1_a = 64'hF0; req1_b = 64'h3C; req1_op = 4'b0000;
        req1_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_result !== 64'd30 || resp_id !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall%0d: valid=%b result=%h id=%b rdy=%b%b busy=%b want 1 1e 0 00 1",
                         i, resp_valid, resp_result, resp_id, req0_ready, req1_ready, busy);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_release: valid=%b req1_ready=%b want 0 1", resp_valid, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 64'h30 || resp_id !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_waiter: valid=%b result=%h id=%b want 1 30 1", resp_valid, resp_result, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic sawValid;
        resp_ready = 1'b1;
        req0_a = 64'd7; req0_b = 64'd8; req0_op = 4'b0010;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_now: busy=%b valid=%b req1_ready=%b want 0 0 0", busy, resp_valid, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || busy !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_dropped: response or busy seen=%b want 0", sawValid);
        end
        req0_a = 64'h100; req0_b = 64'h001; req0_op = 4'b0110;
        req1_a = 64'h3;   req1_b = 64'h4;   req1_op = 4'b0001;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_priority: got %b%b want 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 64'hFF || resp_id !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_next: valid=%b result=%h id=%b err=%b want 1 ff 0 0",
                     resp_valid, resp_result, resp_id, resp_err);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ops();
        test_round_robin();
        test_error();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
